d_fifo_drain_counter: RTL and testbench

Downstream consumer of the transmission layer's two destination FIFOs (D0, D1). Drains both FIFOs with a round-robin pop arbiter into a single registered valid/ready output stream tagged with the destination. Keeps per-destination word counters that the testbench or a host reads back through a req/idx handshake while the transmission logic reports idle.

---
 rtl/d_fifo_drain_counter.sv | 154 +++++++++++++++
 tb/tb_d_fifo_drain_counter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_fifo_drain_counter.sv
// Round-robin drain of the D0/D1 destination FIFOs into one registered valid/ready stream,
// with per-destination pop counters read back through a req/idx pulse. Optional: COUNT_SATURATE_EN.
module d_fifo_drain_counter #(
  parameter int DATA_WIDTH  = 6,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_out_D0,
  input  logic [DATA_WIDTH-1:0]  data_out_D1,
  input  logic                   empty_fifo_D0,
  input  logic                   empty_fifo_D1,
  input  logic                   idle_in,
  input  logic                   out_ready,
  input  logic                   req,
  input  logic [1:0]             idx,
  output logic                   D0_pop,
  output logic                   D1_pop,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   dest_out,
  output logic                   valid_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_valid
);

  typedef enum logic {RD_IDLE, RD_REPORT} rd_state_e;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   dest_q, dest_d;
  logic                   valid_q, valid_d;
  logic                   rr_last_q, rr_last_d;
  logic [COUNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   cvalid_q, cvalid_d;
  rd_state_e              state_q, state_d;

  logic                   slot_free;
  logic                   pop0, pop1;
  logic [COUNT_WIDTH:0]   sum_w;
  logic [COUNT_WIDTH-1:0] sum_sel;
  logic [COUNT_WIDTH-1:0] sel_cnt;

  // Pops are suppressed during reset so no FIFO word is lost to a discarded slot.
  assign slot_free = !valid_q || out_ready;
  assign pop0 = !reset && slot_free && !empty_fifo_D0 && (empty_fifo_D1 || rr_last_q);
  assign pop1 = !reset && slot_free && !empty_fifo_D1 && (empty_fifo_D0 || !rr_last_q);

  always_comb begin
    data_d    = data_q;
    dest_d    = dest_q;
    valid_d   = valid_q;
    rr_last_d = rr_last_q;
    if (pop0) begin
      data_d    = data_out_D0;
      dest_d    = 1'b0;
      valid_d   = 1'b1;
      rr_last_d = 1'b0;
    end else if (pop1) begin
      data_d    = data_out_D1;
      dest_d    = 1'b1;
      valid_d   = 1'b1;
      rr_last_d = 1'b1;
    end else if (slot_free) begin
      valid_d   = 1'b0;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
`ifdef COUNT_SATURATE_EN
    if (pop0 && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_ONE;
    if (pop1 && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_ONE;
`else
    if (pop0) cnt0_d = cnt0_q + CNT_ONE;
    if (pop1) cnt1_d = cnt1_q + CNT_ONE;
`endif
  end

  // Sum is formed one bit wider so the carry tells us whether it overflowed.
  assign sum_w = {1'b0, cnt0_q} + {1'b0, cnt1_q};
`ifdef COUNT_SATURATE_EN
  assign sum_sel = sum_w[COUNT_WIDTH] ? CNT_MAX : sum_w[COUNT_WIDTH-1:0];
`else
  assign sum_sel = sum_w[COUNT_WIDTH-1:0];
`endif

  always_comb begin
    sel_cnt = '0;
    case (idx)
      2'd0:    sel_cnt = cnt0_q;
      2'd1:    sel_cnt = cnt1_q;
      2'd2:    sel_cnt = sum_sel;
      default: sel_cnt = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    cvalid_d = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (req && idle_in) begin
          state_d  = RD_REPORT;
          count_d  = sel_cnt;
          cvalid_d = 1'b1;
        end
      end
      RD_REPORT: begin
        state_d  = RD_IDLE;
        count_d  = '0;
        cvalid_d = 1'b0;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      dest_q    <= 1'b0;
      valid_q   <= 1'b0;
      rr_last_q <= 1'b1;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      count_q   <= '0;
      cvalid_q  <= 1'b0;
      state_q   <= RD_IDLE;
    end else begin
      data_q    <= data_d;
      dest_q    <= dest_d;
      valid_q   <= valid_d;
      rr_last_q <= rr_last_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      count_q   <= count_d;
      cvalid_q  <= cvalid_d;
      state_q   <= state_d;
    end
  end

  assign D0_pop      = pop0;
  assign D1_pop      = pop1;
  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign valid_out   = valid_q;
  assign count_out   = count_q;
  assign count_valid = cvalid_q;

endmodule

// File: tb/tb_d_fifo_drain_counter.sv
// Directed bench for d_fifo_drain_counter: show-ahead FIFO models feed the DUT, each
// scenario task compares outputs against hand-computed values.
module tb_d_fifo_drain_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] data_out_D0, data_out_D1;
  logic       empty_fifo_D0, empty_fifo_D1;
  logic       idle_in, out_ready, req;
  logic [1:0] idx;
  logic       D0_pop, D1_pop;
  logic [5:0] data_out;
  logic       dest_out, valid_out;
  logic [4:0] count_out;
  logic       count_valid;

  int checks = 0;
  int failures = 0;

  logic [5:0] mem0 [0:63];
  logic [5:0] mem1 [0:63];
  logic [5:0] rd0 = '0, wr0 = '0, rd1 = '0, wr1 = '0;

  always #5 clk = ~clk;

  assign data_out_D0   = mem0[rd0];
  assign data_out_D1   = mem1[rd1];
  assign empty_fifo_D0 = (rd0 == wr0);
  assign empty_fifo_D1 = (rd1 == wr1);

  always @(posedge clk) begin
    if (D0_pop) rd0 <= rd0 + 6'd1;
    if (D1_pop) rd1 <= rd1 + 6'd1;
  end

  d_fifo_drain_counter #(.DATA_WIDTH(6), .COUNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .idle_in(idle_in), .out_ready(out_ready), .req(req), .idx(idx),
    .D0_pop(D0_pop), .D1_pop(D1_pop),
    .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out),
    .count_out(count_out), .count_valid(count_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [5:0] w);
    mem0[wr0] = w;
    wr0 = wr0 + 6'd1;
  endtask

  task automatic push1(input logic [5:0] w);
    mem1[wr1] = w;
    wr1 = wr1 + 6'd1;
  endtask

  // Empties both FIFO models and applies a two-cycle reset.
  task automatic do_reset();
    reset = 1'b1; out_ready = 1'b1; req = 1'b0; idle_in = 1'b0; idx = 2'd0;
    wr0 = rd0; wr1 = rd1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; req = 1'b0; idle_in = 1'b1; idx = 2'd0;
    push0(6'd1); push0(6'd2); push1(6'd3);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({D0_pop, D1_pop} !== 2'b00 || valid_out !== 1'b0 || data_out !== 6'd0 ||
          dest_out !== 1'b0 || count_valid !== 1'b0 || count_out !== 5'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d pops=%b%b valid=%b data=%0d dest=%b cv=%b cnt=%0d expected all 0",
                 c, D0_pop, D1_pop, valid_out, data_out, dest_out, count_valid, count_out);
      end
    end
    reset = 1'b0; req = 1'b0;
    #1;
    checks++;
    if (D0_pop !== 1'b1 || D1_pop !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_pop got D0_pop=%b D1_pop=%b expected 1 0", D0_pop, D1_pop);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'd1 || dest_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_word got v=%b d=%0d dest=%b expected 1 1 0", valid_out, data_out, dest_out);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_d [0:4];
    logic       exp_s [0:4];
    exp_d[0] = 6'd10; exp_d[1] = 6'd20; exp_d[2] = 6'd11; exp_d[3] = 6'd21; exp_d[4] = 6'd12;
    exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;  exp_s[4] = 1'b0;
    do_reset();
    push0(6'd10); push0(6'd11); push0(6'd12);
    push1(6'd20); push1(6'd21);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp_d[c] || dest_out !== exp_s[c]) begin
        failures++;
        $display("FAIL rr_word%0d got v=%b d=%0d dest=%b expected 1 %0d %b",
                 c, valid_out, data_out, dest_out, exp_d[c], exp_s[c]);
      end
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || data_out !== 6'd12) begin
      failures++;
      $display("FAIL rr_drained got v=%b d=%0d expected 0 12", valid_out, data_out);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    push0(6'd5); push0(6'd6); push0(6'd7);
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (valid_out !== 1'b1 || data_out !== 6'd5 || D0_pop !== 1'b0 || D1_pop !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%0d pops=%b%b expected 1 5 00",
                 c, valid_out, data_out, D0_pop, D1_pop);
      end
      if (c < 3) tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (D0_pop !== 1'b1) begin
      failures++;
      $display("FAIL stall_resume_pop got D0_pop=%b expected 1", D0_pop);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'd6) begin
      failures++;
      $display("FAIL stall_resume_word got v=%b d=%0d expected 1 6", valid_out, data_out);
    end
  endtask

  task automatic test_counters();
    logic [1:0] ri [0:3];
    logic [4:0] re [0:3];
    ri[0] = 2'd0; ri[1] = 2'd1; ri[2] = 2'd2; ri[3] = 2'd3;
    re[0] = 5'd7; re[1] = 5'd5; re[2] = 5'd12; re[3] = 5'd0;
    do_reset();
    for (int i = 0; i < 7; i++) push0(6'(i));
    for (int i = 0; i < 5; i++) push1(6'(i + 32));
    for (int c = 0; c < 14; c++) tick();
    idle_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idx = ri[k]; req = 1'b1;
      tick();
      req = 1'b0;
      checks++;
      if (count_valid !== 1'b1 || count_out !== re[k]) begin
        failures++;
        $display("FAIL read_idx%0d got cv=%b cnt=%0d expected 1 %0d", k, count_valid, count_out, re[k]);
      end
      tick();
      checks++;
      if (count_valid !== 1'b0 || count_out !== 5'd0) begin
        failures++;
        $display("FAIL read_idx%0d_end got cv=%b cnt=%0d expected 0 0", k, count_valid, count_out);
      end
    end
    idle_in = 1'b0; idx = 2'd0; req = 1'b1;
    tick();
    checks++;
    if (count_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_not_idle got cv=%b expected 0", count_valid);
    end
    idle_in = 1'b1; idx = 2'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (count_valid !== ((c % 2) == 0) || count_out !== (((c % 2) == 0) ? 5'd5 : 5'd0)) begin
        failures++;
        $display("FAIL read_held cyc=%0d got cv=%b cnt=%0d expected %0d %0d",
                 c, count_valid, count_out, (c % 2) == 0, ((c % 2) == 0) ? 5 : 0);
      end
    end
    req = 1'b0; idle_in = 1'b0;
    tick();
  endtask

  task automatic test_wrap_saturate();
    logic [1:0] ri [0:2];
    logic [4:0] re [0:2];
`ifdef COUNT_SATURATE_EN
    re[0] = 5'd31; re[1] = 5'd30; re[2] = 5'd31;
`else
    re[0] = 5'd8;  re[1] = 5'd30; re[2] = 5'd6;
`endif
    ri[0] = 2'd0; ri[1] = 2'd1; ri[2] = 2'd2;
    do_reset();
    for (int i = 0; i < 40; i++) push0(6'(i));
    for (int c = 0; c < 41; c++) tick();
    for (int i = 0; i < 30; i++) push1(6'(i));
    for (int c = 0; c < 31; c++) tick();
    idle_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idx = ri[k]; req = 1'b1;
      tick();
      req = 1'b0;
      checks++;
      if (count_valid !== 1'b1 || count_out !== re[k]) begin
        failures++;
        $display("FAIL wrap_idx%0d got cv=%b cnt=%0d expected 1 %0d", k, count_valid, count_out, re[k]);
      end
      tick();
    end
    idle_in = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    push0(6'd1); push0(6'd2); push0(6'd3);
    push1(6'd4); push1(6'd5); push1(6'd6);
    tick(); tick(); tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'd2 || dest_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre got v=%b d=%0d dest=%b expected 1 2 0", valid_out, data_out, dest_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (D0_pop !== 1'b0 || D1_pop !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_pop got pops=%b%b expected 00", D0_pop, D1_pop);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || data_out !== 6'd0) begin
      failures++;
      $display("FAIL mid_discard got v=%b d=%0d expected 0 0", valid_out, data_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (D0_pop !== 1'b1 || D1_pop !== 1'b0) begin
      failures++;
      $display("FAIL mid_rr_restart got pops=%b%b expected 10", D0_pop, D1_pop);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'd3 || dest_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_next_word got v=%b d=%0d dest=%b expected 1 3 0", valid_out, data_out, dest_out);
    end
    out_ready = 1'b0;
    idle_in = 1'b1; idx = 2'd2; req = 1'b1;
    tick();
    req = 1'b0;
    checks++;
    if (count_valid !== 1'b1 || count_out !== 5'd1) begin
      failures++;
      $display("FAIL mid_counters got cv=%b cnt=%0d expected 1 1", count_valid, count_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_counters();
    test_wrap_saturate();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
